data_gen: RTL and testbench



---
 rtl/seg_pkg.sv | 16 +
 rtl/data_gen_tick_gen.sv | 36 +++
 rtl/data_gen.sv | 67 ++++++
 tb/tb_data_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path (data_gen, seg_dynamic).
package seg_pkg;

  localparam int unsigned DIGITS       = 6;
  localparam int unsigned DATA_W       = 20;
  localparam int unsigned CNT_W        = 23;
  localparam int unsigned CNT_MAX_DEF  = 4_999_999;
  localparam int unsigned DATA_MAX_DEF = 999_999;

  // Next display value: wrap at the configured maximum, otherwise +1.
  function automatic logic [DATA_W-1:0] data_step(input logic [DATA_W-1:0] val,
                                                  input logic [DATA_W-1:0] max);
    return (val == max) ? '0 : val + DATA_W'(1);
  endfunction

endpackage

// File: rtl/data_gen_tick_gen.sv
// Prescaler: free-running counter that flags its terminal count as a one-clock tick.
module tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CNT_MAX);

  // Terminal count must fit the counter width.
  generate
    if (CNT_MAX >= (2 ** CNT_W)) begin : g_cnt_chk
      $error("tick_gen: CNT_MAX does not fit in the prescaler counter");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_TERM);
  assign tick   = w_tick;

  // Prescaler counter: period is CNT_MAX+1 clocks, restarts from 0 on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_gen.sv
// Test-pattern source for the dynamic 7-segment display: a decimal value
// stepping once per prescaler period plus static point/enable/sign controls.
module data_gen
  import seg_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
  parameter int unsigned DATA_MAX = DATA_MAX_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic [DATA_W-1:0] data,
  output logic [DIGITS-1:0] point,
  output logic              seg_en,
  output logic              sign
);

  localparam logic [DATA_W-1:0] DATA_TERM = DATA_W'(DATA_MAX);

  // Display value must be representable on the data bus.
  generate
    if (DATA_MAX >= (2 ** DATA_W)) begin : g_data_chk
      $error("data_gen: DATA_MAX does not fit in DATA_W bits");
    end
  endgenerate

  logic              w_tick;
  logic [DATA_W-1:0] r_data;
  logic [DIGITS-1:0] r_point;
  logic              r_seg_en;
  logic              r_sign;

  tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (w_tick)
  );

  // Display value: advance (with wrap) only on prescaler ticks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data <= '0;
    end else if (w_tick) begin
      r_data <= data_step(r_data, DATA_TERM);
    end
  end

  // Static display controls: no decimal points, positive sign, enable after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_point  <= '0;
      r_seg_en <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      r_point  <= '0;
      r_seg_en <= 1'b1;
      r_sign   <= 1'b0;
    end
  end

  assign data   = r_data;
  assign point  = r_point;
  assign seg_en = r_seg_en;
  assign sign   = r_sign;

endmodule

// File: tb/tb_data_gen.sv
// Bench for data_gen: three instances (default wrap, DATA_MAX=9, CNT_MAX=0)
// on a shared 20 ns clock with independent resets.
module tb_data_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic [19:0] d0, d1, d2;
  logic [5:0]  p0, p1, p2;
  logic        en0, en1, en2;
  logic        sg0, sg1, sg2;

  int          n_vec = 0;
  int          n_mis = 0;
  int          e0    = 0;
  logic [19:0] sb[$];

  data_gen #(.CNT_MAX(49), .DATA_MAX(999_999)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst0), .data(d0), .point(p0), .seg_en(en0), .sign(sg0));

  data_gen #(.CNT_MAX(49), .DATA_MAX(9)) u_wrap (
    .sys_clk(clk), .sys_rst_n(rst1), .data(d1), .point(p1), .seg_en(en1), .sign(sg1));

  data_gen #(.CNT_MAX(0), .DATA_MAX(3)) u_fast (
    .sys_clk(clk), .sys_rst_n(rst2), .data(d2), .point(p2), .seg_en(en2), .sign(sg2));

  task automatic test_reset();
    #5;
    n_vec++; if (d0 !== 20'd0) begin n_mis++; $display("FAIL reset_data: got %0d want 0", d0); end
    n_vec++; if (p0 !== 6'd0) begin n_mis++; $display("FAIL reset_point: got %b want 000000", p0); end
    n_vec++; if (en0 !== 1'b0) begin n_mis++; $display("FAIL reset_seg_en: got %b want 0", en0); end
    n_vec++; if (sg0 !== 1'b0) begin n_mis++; $display("FAIL reset_sign: got %b want 0", sg0); end
    n_vec++; if (d1 !== 20'd0 || en1 !== 1'b0) begin
      n_mis++; $display("FAIL reset_wrap: got data=%0d en=%b want 0/0", d1, en1);
    end
    n_vec++; if (d2 !== 20'd0 || en2 !== 1'b0) begin
      n_mis++; $display("FAIL reset_fast: got data=%0d en=%b want 0/0", d2, en2);
    end
  endtask

  task automatic test_release();
    logic [19:0] exp;
    #15 rst0 = 1'b1;
    e0 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      e0++;
      sb.push_back(20'(e0 / 50));
      @(negedge clk);
      exp = sb.pop_front();
      n_vec++; if (d0 !== exp) begin
        n_mis++; $display("FAIL release_data edge %0d: got %0d want %0d", e0, d0, exp);
      end
      n_vec++; if (en0 !== 1'b1) begin
        n_mis++; $display("FAIL release_seg_en edge %0d: got %b want 1", e0, en0);
      end
    end
  endtask

  task automatic test_long_run();
    logic [19:0] exp;
    logic        chk;
    while (e0 < 50000) begin
      @(posedge clk);
      e0++;
      chk = ((e0 % 50) == 0) || ((e0 % 50) == 49);
      if (chk) sb.push_back(20'(e0 / 50));
      @(negedge clk);
      if (chk) begin
        exp = sb.pop_front();
        n_vec++; if (d0 !== exp) begin
          n_mis++; $display("FAIL long_data edge %0d: got %0d want %0d", e0, d0, exp);
        end
        n_vec++; if (p0 !== 6'd0 || sg0 !== 1'b0) begin
          n_mis++; $display("FAIL long_static edge %0d: got point=%b sign=%b want 0/0", e0, p0, sg0);
        end
      end
    end
    n_vec++; if (d0 !== 20'd1000) begin
      n_mis++; $display("FAIL long_final: got %0d want 1000", d0);
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] exp;
    // Asynchronous clear during the low clock phase.
    @(negedge clk);
    #3 rst0 = 1'b0;
    #1;
    n_vec++; if (d0 !== 20'd0 || en0 !== 1'b0) begin
      n_mis++; $display("FAIL async_clear_low: got data=%0d en=%b want 0/0", d0, en0);
    end
    @(negedge clk);
    rst0 = 1'b1;
    // Count up to data=7, cnt=30 (edge 380 after release).
    for (int k = 1; k <= 380; k++) @(posedge clk);
    #3;
    n_vec++; if (d0 !== 20'd7) begin
      n_mis++; $display("FAIL pre_reset_data: got %0d want 7", d0);
    end
    rst0 = 1'b0;
    #1;
    n_vec++; if (d0 !== 20'd0 || en0 !== 1'b0) begin
      n_mis++; $display("FAIL async_clear_high: got data=%0d en=%b want 0/0", d0, en0);
    end
    n_vec++; if (p0 !== 6'd0 || sg0 !== 1'b0) begin
      n_mis++; $display("FAIL async_clear_static: got point=%b sign=%b want 0/0", p0, sg0);
    end
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    e0 = 0;
    for (int k = 1; k <= 51; k++) begin
      @(posedge clk);
      e0++;
      sb.push_back(20'(e0 / 50));
      @(negedge clk);
      exp = sb.pop_front();
      n_vec++; if (d0 !== exp || en0 !== 1'b1) begin
        n_mis++; $display("FAIL restart edge %0d: got data=%0d en=%b want %0d/1", e0, d0, en0, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [19:0] exp;
    @(negedge clk);
    rst1 = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      sb.push_back(20'((k / 50) % 10));
      @(negedge clk);
      exp = sb.pop_front();
      n_vec++; if (d1 !== exp) begin
        n_mis++; $display("FAIL wrap_data edge %0d: got %0d want %0d", k, d1, exp);
      end
    end
    n_vec++; if (en1 !== 1'b1 || p1 !== 6'd0 || sg1 !== 1'b0) begin
      n_mis++; $display("FAIL wrap_static: got en=%b point=%b sign=%b want 1/0/0", en1, p1, sg1);
    end
  endtask

  task automatic test_fast();
    logic [19:0] exp;
    @(negedge clk);
    rst2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      sb.push_back(20'(k % 4));
      @(negedge clk);
      exp = sb.pop_front();
      n_vec++; if (d2 !== exp) begin
        n_mis++; $display("FAIL fast_data edge %0d: got %0d want %0d", k, d2, exp);
      end
    end
  endtask

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    test_reset();
    test_release();
    test_long_run();
    test_mid_reset();
    test_wrap();
    test_fast();
    n_vec++; if (sb.size() != 0) begin
      n_mis++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
